// File: rtl/cntr_capture.sv
// cntr_capture: timestamp capture stage fed by a free-running counter.
// A rising edge on the asynchronous evt_i records the current counter
// value into a small first-word-fall-through FIFO. Consumers drain the
// FIFO through a valid/ready handshake. A sticky flag reports events lost
// because the FIFO was full.
`timescale 1ns/1ps

module cntr_capture #(
   parameter int COUNTER_WIDTH = 8,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [COUNTER_WIDTH-1:0]     cntr_i,
   input  logic                         evt_i,
   input  logic                         cap_en_i,
   output logic [COUNTER_WIDTH-1:0]     cap_data_o,
   output logic                         cap_valid_o,
   input  logic                         cap_ready_i,
   output logic                         ovf_o,
   input  logic                         ovf_clr_i,
   output logic [$clog2(FIFO_DEPTH):0]  level_o
);

   // Address width indexes the storage; pointer width adds one wrap bit
   // so that full and empty can be told apart when the addresses match.
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;

   // Depth must be a power of two so the pointers can wrap naturally.
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("cntr_capture: FIFO_DEPTH must be a power of 2 and at least 2");
   end

   // ------------------------------------------------------------------
   // Event synchronizer and edge detector
   // ------------------------------------------------------------------
   logic r_s1;
   logic r_s2;
   logic r_s3;
   logic w_evt_rise;

   // Two-flop synchronizer followed by a history flop for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments shift the chain one stage per edge;
         // blocking ones would collapse s1/s2/s3 into a single flop.
         r_s1 <= evt_i;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_evt_rise = r_s2 & ~r_s3;

   // ------------------------------------------------------------------
   // FIFO pointers and status
   // ------------------------------------------------------------------
   logic [PW-1:0]            r_wr_ptr;
   logic [PW-1:0]            r_rd_ptr;
   logic [COUNTER_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic                     r_ovf;

   logic w_empty;
   logic w_full;
   logic w_push_req;
   logic w_pop;
   logic w_push;
   logic w_drop;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   // Decode this cycle's push, pop and drop from the handshake and status.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      w_push_req = 1'b0;
      w_pop      = 1'b0;
      w_push     = 1'b0;
      w_drop     = 1'b0;

      w_push_req = w_evt_rise & cap_en_i;
      w_pop      = ~w_empty & cap_ready_i;
      // A full FIFO still accepts a push when the head leaves in the same
      // cycle; the freed slot is exactly the one being written.
      if (w_push_req) begin
         if (!w_full || w_pop) begin
            w_push = 1'b1;
         end else begin
            w_drop = 1'b1;
         end
      end
   end

   // Advance the write and read pointers on accepted push and pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
      end
   end

   // Capture storage: write the counter value seen at the write edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: storage is cleared on reset so the fall-through head reads
         // 0 rather than X while empty; it is small enough to afford it.
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= cntr_i;
      end
   end

   // Sticky overflow: a drop sets it and wins over a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end else if (ovf_clr_i) begin
         r_ovf <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign cap_data_o  = r_mem[r_rd_ptr[AW-1:0]];
   assign cap_valid_o = ~w_empty;
   assign ovf_o       = r_ovf;
   assign level_o     = r_wr_ptr - r_rd_ptr;

endmodule
